instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, meaning the addi x0,x0,0 bubble placed in IF/ID.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 stall  in  1  hazard unit request to hold the PC and IF/ID.
REQ-006 redirect_valid  in  1  taken branch or jump resolved downstream; flush the fetch path.
REQ-007 redirect_target  in  32  byte address of the redirect destination.
REQ-008 imem_addr  out  30  word address to the instruction memory, equal to pc[31:2], combinational from the PC register.
REQ-009 imem_data  in  32  instruction word returned combinationally by the instruction memory for imem_addr.
REQ-010 ifid_pc, ifid_pc_plus4, ifid_instr  out  32 each  IF/ID register contents.
REQ-011 ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
REQ-012 halted  out  1  fetch FSM is in HALTED.
REQ-013 misalign_fault  out  1  sticky flag: a redirect target had target[1:0] != 0.
REQ-014 fetch_count  out  32  number of valid instructions loaded into IF/ID.

Function
REQ-015 FSM states: RUN and HALTED; there is one PC register, and imem_addr always reflects it.
REQ-016 In RUN with no stall and no redirect: pc <= pc+4; IF/ID <= {pc, pc+4, imem_data}; ifid_valid <= 1. Latency is 1 cycle from PC to IF/ID.
REQ-017 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. ifid_pc_plus4 wraps the same way.
REQ-018 stall=1 with redirect_valid=0: pc, IF/ID, fetch_count and state all hold.
REQ-019 redirect_valid=1 overrides stall and is honoured in every state. Effects: pc <= {redirect_target[31:2],2'b00}; IF/ID <= {0, 0, NOP_INSTR}; ifid_valid <= 0; state <= RUN.
REQ-020 If redirect_target[1:0] != 0 during a redirect, misalign_fault is set to 1 and stays set until rst. The redirect still proceeds per REQ-019.
REQ-021 In RUN, loading 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) into IF/ID with ifid_valid=1 moves the state to HALTED on the same edge, and pc still advances by 4.
REQ-022 In HALTED without redirect: pc holds; IF/ID <= {0, 0, NOP_INSTR} with ifid_valid=0 each cycle; stall has no effect.
REQ-023 fetch_count increments by 1 on each edge that loads IF/ID with ifid_valid=1. It wraps at 2^32 and holds otherwise.
REQ-024 halted is 1 exactly when the state is HALTED.

Reset
REQ-025 On rst=1 at an edge, all of the following take effect regardless of stall or redirect:
- pc <= RESET_PC and state <= RUN
- ifid_pc <= 0, ifid_pc_plus4 <= 0, ifid_instr <= NOP_INSTR, ifid_valid <= 0
- misalign_fault <= 0 and fetch_count <= 0
REQ-026 A reset asserted mid-stall, mid-halt or concurrently with a redirect discards that operation. The first fetch after rst deasserts uses RESET_PC.

Structure
REQ-027 A shared package holds NOP_INSTR, the ECALL and EBREAK encodings, the default RESET_PC, and the FSM state enumeration (RUN, HALTED).
REQ-028 One sub-module, if_id_reg, implements the IF/ID register with load, flush-to-bubble and synchronous reset controls. The PC, FSM and counter remain in instruction_fetch_stage.

Verification
REQ-029 Sequential fetch: after reset, with imem returning 0x00500093 at word 0 and 0x00100113 at word 1, then 2 clocks → IF/ID shows pc=0/instr=0x00500093, then pc=4/instr=0x00100113; imem_addr=2; fetch_count=2.
REQ-030 Stall: with pc=8, hold stall=1 for 3 cycles → pc, imem_addr and IF/ID unchanged and fetch_count constant. Releasing stall resumes at pc=8→12.
REQ-031 Redirect during stall: with stall=1 and redirect_valid=1, target=0x40 → next cycle pc=0x40, ifid_valid=0, ifid_instr=0x00000013, misalign_fault=0. The cycle after that loads word 0x10.
REQ-032 Misaligned redirect: target=0x42 → pc=0x40 and misalign_fault=1. The fault remains 1 through 10 further cycles and clears only on rst.
REQ-033 Halt: fetching 0x00000073 at pc=0x10 → halted=1 on that edge and pc=0x14 thereafter, with bubbles only and fetch_count frozen. A redirect to 0x0 then returns to RUN with halted=0.
REQ-034 Wrap and reset: with RESET_PC=32'hFFFF_FFFC, after reset and 1 clock → ifid_pc=0xFFFFFFFC, ifid_pc_plus4=0 and pc=0. Asserting rst while halted restores pc=RESET_PC and halted=0.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] ECALL_INSTR       = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR      = 32'h0010_0073;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Reset and flush both produce a bubble; flush beats load.
module if_id_reg
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (flush_i) begin
      pc_d       = 32'd0;
      pc_plus4_d = 32'd0;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
    end else if (load_i) begin
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      instr_d    = instr_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: PC register, RUN/HALTED FSM, fetch counter and misalign flag.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misalign_fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;
  logic [31:0]  pc_plus4;
  logic         fire;
  logic         flush;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    fire    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over stall and over HALTED.
      pc_d    = {redirect_target[31:2], 2'b00};
      state_d = RUN;
      flush   = 1'b1;
      if (redirect_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            fire    = 1'b1;
            pc_d    = pc_plus4;
            count_d = count_q + 32'd1;
            if (is_halt_instr(imem_data)) begin
              state_d = HALTED;
            end
          end
        end
        HALTED: begin
          flush = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fire),
    .flush_i    (flush),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (imem_data),
    .pc_o       (ifid_pc),
    .pc_plus4_o (ifid_pc_plus4),
    .instr_o    (ifid_instr),
    .valid_o    (ifid_valid)
  );

  assign imem_addr      = pc_q[31:2];
  assign halted         = (state_q == HALTED);
  assign misalign_fault = fault_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: one DUT at RESET_PC=0, one at the wrap point.
module tb_instruction_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  // DUT A, RESET_PC = 0
  logic        rst_a, stall_a, redir_a;
  logic [31:0] target_a;
  logic [29:0] addr_a;
  logic [31:0] data_a, pc_a, pc4_a, instr_a, count_a;
  logic        valid_a, halted_a, fault_a;

  // DUT B, RESET_PC = 0xFFFF_FFFC
  logic        rst_b, stall_b, redir_b;
  logic [31:0] target_b;
  logic [29:0] addr_b;
  logic [31:0] data_b, pc_b, pc4_b, instr_b, count_b;
  logic        valid_b, halted_b, fault_b;

  assign data_a = mem[addr_a[5:0]];
  assign data_b = mem[addr_b[5:0]];

  instruction_fetch_stage dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .redirect_valid(redir_a),
    .redirect_target(target_a), .imem_addr(addr_a), .imem_data(data_a),
    .ifid_pc(pc_a), .ifid_pc_plus4(pc4_a), .ifid_instr(instr_a),
    .ifid_valid(valid_a), .halted(halted_a), .misalign_fault(fault_a),
    .fetch_count(count_a)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .redirect_valid(redir_b),
    .redirect_target(target_b), .imem_addr(addr_b), .imem_data(data_b),
    .ifid_pc(pc_b), .ifid_pc_plus4(pc4_b), .ifid_instr(instr_b),
    .ifid_valid(valid_b), .halted(halted_b), .misalign_fault(fault_b),
    .fetch_count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[4] = 32'h0000_0073;

    rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; target_a = 32'd0;
    rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; target_b = 32'd0;
    tick();
    tick();

    // Reset state of A
    chk("rst_addr", {2'b00, addr_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_instr", instr_a, 32'h0000_0013);
    chk("rst_ifid_pc", pc_a, 32'd0);
    chk("rst_count", count_a, 32'd0);
    chk("rst_halted", {31'd0, halted_a}, 32'd0);
    chk("rst_fault", {31'd0, fault_a}, 32'd0);
    $display("reset A: addr=%h count=%0d", addr_a, count_a);

    // Sequential fetch
    rst_a = 1'b0;
    tick();
    chk("seq0_pc", pc_a, 32'd0);
    chk("seq0_pc4", pc4_a, 32'd4);
    chk("seq0_instr", instr_a, 32'h0050_0093);
    chk("seq0_valid", {31'd0, valid_a}, 32'd1);
    $display("fetch: ifid_pc=%h instr=%h", pc_a, instr_a);
    tick();
    chk("seq1_pc", pc_a, 32'd4);
    chk("seq1_instr", instr_a, 32'h0010_0113);
    chk("seq1_addr", {2'b00, addr_a}, 32'd2);
    chk("seq1_count", count_a, 32'd2);
    $display("fetch: ifid_pc=%h instr=%h addr=%h count=%0d", pc_a, instr_a, addr_a, count_a);

    // Stall holds everything
    stall_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", {2'b00, addr_a}, 32'd2);
      chk("stall_ifid_pc", pc_a, 32'd4);
      chk("stall_instr", instr_a, 32'h0010_0113);
      chk("stall_count", count_a, 32'd2);
      $display("stall %0d: addr=%h ifid_pc=%h count=%0d", i, addr_a, pc_a, count_a);
    end
    stall_a = 1'b0;
    tick();
    chk("resume_ifid_pc", pc_a, 32'd8);
    chk("resume_instr", instr_a, 32'h1000_0002);
    chk("resume_addr", {2'b00, addr_a}, 32'd3);
    chk("resume_count", count_a, 32'd3);
    $display("resume: ifid_pc=%h addr=%h count=%0d", pc_a, addr_a, count_a);

    // Redirect during stall
    stall_a = 1'b1; redir_a = 1'b1; target_a = 32'h40;
    tick();
    chk("redir_addr", {2'b00, addr_a}, 32'h10);
    chk("redir_valid", {31'd0, valid_a}, 32'd0);
    chk("redir_instr", instr_a, 32'h0000_0013);
    chk("redir_ifid_pc", pc_a, 32'd0);
    chk("redir_fault", {31'd0, fault_a}, 32'd0);
    chk("redir_count", count_a, 32'd3);
    $display("redirect: addr=%h valid=%b instr=%h", addr_a, valid_a, instr_a);
    stall_a = 1'b0; redir_a = 1'b0;
    tick();
    chk("post_redir_pc", pc_a, 32'h40);
    chk("post_redir_instr", instr_a, 32'h1000_0010);
    chk("post_redir_valid", {31'd0, valid_a}, 32'd1);
    chk("post_redir_count", count_a, 32'd4);
    $display("fetch: ifid_pc=%h instr=%h", pc_a, instr_a);

    // Misaligned redirect
    redir_a = 1'b1; target_a = 32'h42;
    tick();
    redir_a = 1'b0;
    chk("mis_addr", {2'b00, addr_a}, 32'h10);
    chk("mis_fault", {31'd0, fault_a}, 32'd1);
    $display("misaligned redirect: addr=%h fault=%b", addr_a, fault_a);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mis_sticky", {31'd0, fault_a}, 32'd1);
      chk("mis_ifid_pc", pc_a, 32'h40 + 32'(4 * i));
    end
    chk("mis_count", count_a, 32'd14);
    $display("after 10 cycles: fault=%b count=%0d", fault_a, count_a);

    // Halt on ECALL at 0x10
    redir_a = 1'b1; target_a = 32'h10;
    tick();
    redir_a = 1'b0;
    chk("pre_halt_addr", {2'b00, addr_a}, 32'h4);
    tick();
    chk("halt_halted", {31'd0, halted_a}, 32'd1);
    chk("halt_instr", instr_a, 32'h0000_0073);
    chk("halt_valid", {31'd0, valid_a}, 32'd1);
    chk("halt_addr", {2'b00, addr_a}, 32'h5);
    chk("halt_count", count_a, 32'd15);
    $display("halt: halted=%b addr=%h count=%0d", halted_a, addr_a, count_a);
    for (int i = 0; i < 3; i++) begin
      stall_a = (i == 1);
      tick();
      chk("halted_hold", {31'd0, halted_a}, 32'd1);
      chk("halted_addr", {2'b00, addr_a}, 32'h5);
      chk("halted_valid", {31'd0, valid_a}, 32'd0);
      chk("halted_instr", instr_a, 32'h0000_0013);
      chk("halted_count", count_a, 32'd15);
    end
    stall_a = 1'b0;
    redir_a = 1'b1; target_a = 32'h0;
    tick();
    redir_a = 1'b0;
    chk("unhalt_halted", {31'd0, halted_a}, 32'd0);
    chk("unhalt_addr", {2'b00, addr_a}, 32'd0);
    $display("unhalt: halted=%b addr=%h", halted_a, addr_a);

    // Reset clears the sticky fault
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("rst_clears_fault", {31'd0, fault_a}, 32'd0);
    chk("rst_clears_count", count_a, 32'd0);
    $display("reset A again: fault=%b count=%0d", fault_a, count_a);

    // DUT B: wrap at the top of the address space
    chk("b_rst_addr", {2'b00, addr_b}, 32'h3FFF_FFFF);
    chk("b_rst_valid", {31'd0, valid_b}, 32'd0);
    rst_b = 1'b0;
    tick();
    chk("b_wrap_ifid_pc", pc_b, 32'hFFFF_FFFC);
    chk("b_wrap_pc4", pc4_b, 32'd0);
    chk("b_wrap_instr", instr_b, 32'h1000_003F);
    chk("b_wrap_addr", {2'b00, addr_b}, 32'd0);
    $display("wrap: ifid_pc=%h pc4=%h addr=%h", pc_b, pc4_b, addr_b);

    redir_b = 1'b1; target_b = 32'h10;
    tick();
    redir_b = 1'b0;
    tick();
    chk("b_halted", {31'd0, halted_b}, 32'd1);
    // Reset concurrent with a redirect while halted
    rst_b = 1'b1; redir_b = 1'b1; target_b = 32'h42;
    tick();
    rst_b = 1'b0; redir_b = 1'b0;
    chk("b_rst_halt_addr", {2'b00, addr_b}, 32'h3FFF_FFFF);
    chk("b_rst_halt_halted", {31'd0, halted_b}, 32'd0);
    chk("b_rst_halt_fault", {31'd0, fault_b}, 32'd0);
    chk("b_rst_halt_count", count_b, 32'd0);
    $display("reset B while halted: addr=%h halted=%b", addr_b, halted_b);
    tick();
    chk("b_first_fetch_pc", pc_b, 32'hFFFF_FFFC);
    $display("fetch B: ifid_pc=%h", pc_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
